// File: rtl/wb_slave_pipelined_ram.sv
// Wishbone B4 pipelined-mode slave with an internal single-port RAM.
// Features: byte selects, in-order acknowledge of multiple outstanding requests,
// per-request wait states, outstanding-limit back-pressure and cycle-abort flush.
// Optional: define WB_SLAVE_ADDR_ERR_EN to answer out-of-range addresses with err
// instead of wrapping them modulo DEPTH_WORDS.
module wb_slave_pipelined_ram #(
  parameter int DW              = 16,
  parameter int AW              = 16,
  parameter int DEPTH_WORDS     = 2**AW,
  parameter int RD_LATENCY      = 1,
  parameter int MAX_OUTSTANDING = 4,
  parameter int WAITCYCLES      = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cyc,
  input  logic            stb,
  input  logic            we,
  input  logic [AW-1:0]   adr,
  input  logic [DW/8-1:0] sel,
  input  logic [DW-1:0]   dat_i,
  output logic [DW-1:0]   dat_o,
  output logic            ack,
  output logic            err,
  output logic            stall
);

  localparam int          SW      = DW / 8;
  localparam int          IW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int          LAST    = RD_LATENCY - 1;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_L  = 4'(WAITCYCLES);
  localparam logic [3:0]  MAX_L   = 4'(MAX_OUTSTANDING);

  logic [DW-1:0] mem [DEPTH_WORDS];

  // Retirement pipeline: one slot per cycle of latency, oldest at index LAST.
  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [RD_LATENCY-1:0] we_sh_q, we_sh_d;
  logic [RD_LATENCY-1:0] err_sh_q, err_sh_d;
  logic [DW-1:0]         dat_sh_q [RD_LATENCY];
  logic [DW-1:0]         dat_sh_d [RD_LATENCY];
  logic [3:0]            wcnt_q, wcnt_d;
  logic [3:0]            outst_q, outst_d;

  logic          req, accept, retire, addr_bad;
  logic [AW:0]   adr_x;
  logic [IW-1:0] idx;

  assign req    = cyc & stb;
  // A retiring slot only counts while the cycle is alive; an abort swallows it.
  assign retire = vld_q[LAST] & cyc;
  assign stall  = req & ((wcnt_q != 4'd0) | ((outst_q == MAX_L) & ~retire));
  assign accept = req & ~stall;

  assign adr_x = {1'b0, adr};
  assign idx   = IW'(adr_x % DEPTH_L);
`ifdef WB_SLAVE_ADDR_ERR_EN
  assign addr_bad = (adr_x >= DEPTH_L);
`else
  assign addr_bad = 1'b0;
`endif

  // Next state of the wait counter, outstanding counter and retirement pipeline.
  always_comb begin
    wcnt_d   = wcnt_q;
    outst_d  = outst_q;
    vld_d    = '0;
    we_sh_d  = '0;
    err_sh_d = '0;
    dat_sh_d = dat_sh_q;

    if (!req || accept) wcnt_d = WAIT_L;
    else if (wcnt_q != 4'd0) wcnt_d = wcnt_q - 4'd1;

    if (accept && !retire) outst_d = outst_q + 4'd1;
    else if (!accept && retire) outst_d = outst_q - 4'd1;

    for (int i = LAST; i > 0; i--) begin
      vld_d[i]    = vld_q[i-1];
      we_sh_d[i]  = we_sh_q[i-1];
      err_sh_d[i] = err_sh_q[i-1];
      dat_sh_d[i] = dat_sh_q[i-1];
    end
    vld_d[0]    = accept;
    we_sh_d[0]  = we;
    err_sh_d[0] = addr_bad;
    dat_sh_d[0] = (we || addr_bad) ? '0 : mem[idx];

    if (!cyc) begin
      vld_d   = '0;
      outst_d = 4'd0;
    end
  end

  // Control state: counters and slot flags, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q   <= WAIT_L;
      outst_q  <= 4'd0;
      vld_q    <= '0;
      we_sh_q  <= '0;
      err_sh_q <= '0;
    end else begin
      wcnt_q   <= wcnt_d;
      outst_q  <= outst_d;
      vld_q    <= vld_d;
      we_sh_q  <= we_sh_d;
      err_sh_q <= err_sh_d;
    end
  end

  // Slot data travels without reset; it is only visible through a valid ack.
  always_ff @(posedge clk) begin
    dat_sh_q <= dat_sh_d;
  end

  // Byte-lane RAM write at the accept edge; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (accept && we && !addr_bad) begin
      for (int i = 0; i < SW; i++) begin
        if (sel[i]) mem[idx][8*i +: 8] <= dat_i[8*i +: 8];
      end
    end
  end

  assign ack   = retire & ~err_sh_q[LAST];
`ifdef WB_SLAVE_ADDR_ERR_EN
  assign err   = retire & err_sh_q[LAST];
`else
  assign err   = 1'b0;
`endif
  assign dat_o = (ack && !we_sh_q[LAST]) ? dat_sh_q[LAST] : '0;

endmodule
